// File: rtl/aixh_mxc_left_qtile_iscell.sv
// Input-side cell of the MxConv left queue tile: a small FIFO feeds a hold-aware skew
// pipe that delays each row word by SKEW_DEPTH cycles before the horizontal write port.
module aixh_mxc_left_qtile_iscell #(
    parameter int DWIDTH     = 16,
    parameter int SKEW_DEPTH = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          aixh_core_clk,
    input  logic                          aixh_core_rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [DWIDTH-1:0]             i_data,
    input  logic                          i_last,
    input  logic                          i_flush,
    input  logic                          i_hold,
    output logic                          o_wenable,
    output logic [DWIDTH-1:0]             o_wdata,
    output logic                          o_wlast,
    output logic                          o_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_idle
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    logic [DWIDTH:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         level;
    logic                  done_q;

    logic [SKEW_DEPTH-1:0] stg_valid;
    logic [SKEW_DEPTH-1:0] stg_last;
    logic [DWIDTH-1:0]     stg_data [SKEW_DEPTH];

    logic                  push;
    logic                  pop;
    logic [DWIDTH:0]       head;

    // Handshake: a word transfers on any rising edge where i_valid and o_ready are both high;
    // o_ready depends only on the registered level, so it never combinationally follows i_valid.
    assign o_ready = (level < LW'(FIFO_DEPTH));
    assign push    = i_valid & o_ready;
    assign pop     = (level != '0) & ~i_hold & ~i_flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge aixh_core_clk) begin
        if (aixh_core_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            stg_valid <= '0;
            done_q    <= 1'b0;
        end else begin
            // A last word that is flushed in the same cycle it is consumed does not report done.
            done_q <= stg_valid[SKEW_DEPTH-1] & stg_last[SKEW_DEPTH-1] & ~i_hold & ~i_flush;
            if (i_flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                level     <= '0;
                stg_valid <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                unique case ({push, pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
                if (!i_hold) begin
                    for (int k = 1; k < SKEW_DEPTH; k++) begin
                        stg_valid[k] <= stg_valid[k-1];
                    end
                    stg_valid[0] <= pop;
                end
            end
        end
    end

    // Payload registers carry no reset; their validity is tracked by stg_valid and level.
    always_ff @(posedge aixh_core_clk) begin
        if (push && !i_flush) begin
            mem[wr_ptr] <= {i_last, i_data};
        end
        if (!i_hold) begin
            for (int k = 1; k < SKEW_DEPTH; k++) begin
                stg_data[k] <= stg_data[k-1];
                stg_last[k] <= stg_last[k-1];
            end
            stg_data[0] <= head[DWIDTH-1:0];
            stg_last[0] <= head[DWIDTH];
        end
    end

    assign o_wenable = stg_valid[SKEW_DEPTH-1];
    assign o_wdata   = stg_data[SKEW_DEPTH-1];
    assign o_wlast   = stg_valid[SKEW_DEPTH-1] & stg_last[SKEW_DEPTH-1];
    assign o_done    = done_q;
    assign o_level   = level;
    assign o_idle    = (level == '0) & ~|stg_valid;

endmodule

// File: tb/tb_aixh_mxc_left_qtile_iscell.sv
// Self-checking bench for aixh_mxc_left_qtile_iscell: directed scenarios plus random
// streams compared against a queue-based reference model and an ordered scoreboard.
module tb_aixh_mxc_left_qtile_iscell;

    localparam int DW = 16;
    localparam int SK = 3;
    localparam int FD = 4;
    localparam int LW = $clog2(FD) + 1;

    logic          aixh_core_clk;
    logic          aixh_core_rst;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic          i_last;
    logic          i_flush;
    logic          i_hold;
    logic          o_wenable;
    logic [DW-1:0] o_wdata;
    logic          o_wlast;
    logic          o_done;
    logic [LW-1:0] o_level;
    logic          o_idle;

    aixh_mxc_left_qtile_iscell #(
        .DWIDTH     (DW),
        .SKEW_DEPTH (SK),
        .FIFO_DEPTH (FD)
    ) dut (
        .aixh_core_clk (aixh_core_clk),
        .aixh_core_rst (aixh_core_rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_data        (i_data),
        .i_last        (i_last),
        .i_flush       (i_flush),
        .i_hold        (i_hold),
        .o_wenable     (o_wenable),
        .o_wdata       (o_wdata),
        .o_wlast       (o_wlast),
        .o_done        (o_done),
        .o_level       (o_level),
        .o_idle        (o_idle)
    );

    // Clock and watchdog
    initial begin
        aixh_core_clk = 1'b0;
        forever #5 aixh_core_clk = ~aixh_core_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    // Scoreboard and reference model state
    logic [DW:0]   exp_q[$];
    logic [DW:0]   fq[$];
    logic          m_v[SK];
    logic [DW-1:0] m_d[SK];
    logic          m_l[SK];
    logic          m_done;
    bit            m_known;
    int            n_checks;
    int            n_pass;
    int            n_push;
    int            n_pop;
    int            n_done;
    int            n_nrdy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic bit m_pipe_busy();
        bit b;
        b = 1'b0;
        for (int i = 0; i < SK; i++) b |= m_v[i];
        return b;
    endfunction

    // One clock cycle: drive inputs, score consumption, advance the model, compare outputs.
    task automatic step(input logic r, input logic v, input logic [DW-1:0] d,
                        input logic l, input logic f, input logic h);
        bit            pushm;
        bit            popm;
        logic [DW:0]   hd;
        logic [DW:0]   e;
        aixh_core_rst = r;
        i_valid       = v;
        i_data        = d;
        i_last        = l;
        i_flush       = f;
        i_hold        = h;
        hd            = '0;
        #1;
        pushm = v && (fq.size() < FD);
        if (m_known) begin
            chk("ready", o_ready, fq.size() < FD);
            if (o_ready !== 1'b1) n_nrdy++;
            if (o_wenable === 1'b1 && !h) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    chk("sb_extra_word", {o_wlast, o_wdata}, 32'hdead);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_order", {o_wlast, o_wdata}, e);
                end
            end
        end
        if (r) begin
            fq.delete();
            exp_q.delete();
            for (int i = 0; i < SK; i++) m_v[i] = 1'b0;
            m_done  = 1'b0;
            m_known = 1'b1;
        end else begin
            m_done = m_v[SK-1] && m_l[SK-1] && !h && !f;
            if (f) begin
                fq.delete();
                exp_q.delete();
                for (int i = 0; i < SK; i++) m_v[i] = 1'b0;
            end else begin
                popm = !h && (fq.size() > 0);
                if (popm) hd = fq.pop_front();
                if (pushm) begin
                    fq.push_back({l, d});
                    exp_q.push_back({l, d});
                    n_push++;
                end
                if (!h) begin
                    for (int i = SK - 1; i > 0; i--) begin
                        m_v[i] = m_v[i-1];
                        m_d[i] = m_d[i-1];
                        m_l[i] = m_l[i-1];
                    end
                    m_v[0] = popm;
                    m_d[0] = hd[DW-1:0];
                    m_l[0] = hd[DW];
                end
            end
        end
        @(posedge aixh_core_clk);
        @(negedge aixh_core_clk);
        if (o_done === 1'b1) n_done++;
        chk("level", o_level, fq.size());
        chk("wenable", o_wenable, m_v[SK-1]);
        chk("wlast", o_wlast, m_v[SK-1] && m_l[SK-1]);
        if (m_v[SK-1]) chk("wdata", o_wdata, m_d[SK-1]);
        chk("done", o_done, m_done);
        chk("idle", o_idle, (fq.size() == 0) && !m_pipe_busy());
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && o_idle !== 1'b1; i++) idle_step();
        chk("drain_idle", o_idle, 1);
    endtask

    // Counts cycles from a handshake step until o_wenable rises, bounded.
    task automatic measure_latency(input string tag);
        int lat;
        lat = 1;
        while (o_wenable !== 1'b1 && lat < 20) begin
            idle_step();
            lat++;
        end
        chk(tag, lat, SK + 1);
    endtask

    initial begin
        int base;
        int p0;
        int c0;
        m_known = 1'b0;
        n_checks = 0; n_pass = 0; n_push = 0; n_pop = 0; n_done = 0; n_nrdy = 0;
        m_done = 1'b0;
        for (int i = 0; i < SK; i++) begin
            m_v[i] = 1'b0; m_d[i] = '0; m_l[i] = 1'b0;
        end
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("rst_ready", o_ready, 1);
        chk("rst_wenable", o_wenable, 0);
        chk("rst_level", o_level, 0);
        chk("rst_idle", o_idle, 1);

        // Single word latency and idle recovery
        step(1'b0, 1'b1, 16'h00A5, 1'b0, 1'b0, 1'b0);
        measure_latency("t1_latency");
        chk("t1_wdata", o_wdata, 16'h00A5);
        idle_step();
        chk("t1_idle", o_idle, 1);
        drain();

        // Back-to-back stream, single done pulse
        base = n_nrdy;
        c0   = n_done;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, DW'(i), i == 7, 1'b0, 1'b0);
        drain();
        for (int i = 0; i < 3; i++) idle_step();
        chk("t2_ready_high", n_nrdy - base, 0);
        chk("t2_done_once", n_done - c0, 1);

        // Hold with back-pressure
        base = n_nrdy;
        p0   = n_push;
        for (int c = 0; c < 14; c++) begin
            step(1'b0, (n_push - p0) < 6, DW'($urandom), 1'b0, 1'b0, (c >= 2 && c <= 9));
        end
        chk("t3_ready_fell", (n_nrdy - base) > 0, 1);
        drain();
        chk("t3_all_pushed", n_push - p0, 6);

        // Flush beats same-cycle push
        for (int i = 0; i < FD; i++) step(1'b0, 1'b1, DW'($urandom), 1'b0, 1'b0, 1'b1);
        chk("t4_full", o_level, FD);
        step(1'b0, 1'b1, 16'h00EE, 1'b0, 1'b1, 1'b1);
        chk("t4_level0", o_level, 0);
        chk("t4_wen0", o_wenable, 0);
        chk("t4_idle", o_idle, 1);
        drain();

        // Random hold stream with pointer wrap
        p0 = n_push;
        c0 = n_pop;
        for (int c = 0; c < 400 && (n_push - p0) < 20; c++) begin
            step(1'b0, 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'b0, 1'($urandom_range(0, 1)));
        end
        drain();
        chk("t5_consumed", n_pop - c0, 20);

        // Reset with words in flight and a last pending
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DW'(16'h100 + i), i == 2, 1'b0, 1'b0);
        idle_step();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("t6_done0", o_done, 0);
        chk("t6_wen0", o_wenable, 0);
        step(1'b0, 1'b1, 16'h005A, 1'b1, 1'b0, 1'b0);
        measure_latency("t6_latency");
        chk("t6_wdata", o_wdata, 16'h005A);
        drain();

        // Long random run with occasional flush and reset
        for (int c = 0; c < 300; c++) begin
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 2) != 0), DW'($urandom),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 2) == 0));
        end
        drain();
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aixh_mxc_left_qtile_iscell.md
Name: aixh_mxc_left_qtile_iscell

Overview:
Input-side cell of the MxConv left queue tile. It accepts row data from the queue-tile write path with a valid/ready handshake and buffers it in a small FIFO. A hold-aware skew pipeline delays each word by SKEW_DEPTH cycles, so each row enters the array at its diagonal offset. Outputs drive the horizontal write interface (wenable/wdata) consumed by the output-side cells. The whole block runs on the 1x core clock.

Parameters:
DWIDTH, LQCELL_FWD_DWIDTH (package constant), width of one row word
SKEW_DEPTH, 1, number of skew register stages (legal values 1..16)
FIFO_DEPTH, 4, input buffer entries (power of two, 2..16)

Ports:
aixh_core_clk  input  1  core clock; all logic on the rising edge
aixh_core_rst  input  1  synchronous reset, active-high
i_valid  input  1  upstream word valid
o_ready  output  1  FIFO can accept a word
i_data  input  DWIDTH  upstream word
i_last  input  1  word is the last of a tile
i_flush  input  1  synchronous clear of buffered and in-flight words
i_hold  input  1  array back-pressure; freezes the skew pipe
o_wenable  output  1  tail stage holds a valid word
o_wdata  output  DWIDTH  tail stage word
o_wlast  output  1  tail stage last tag
o_done  output  1  single-cycle pulse when the last word is consumed
o_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
o_idle  output  1  FIFO empty and all stage valids clear

Behaviour:
Clock and reset:
- One clock (aixh_core_clk).
- Reset is synchronous and active-high (aixh_core_rst).
- Reset clears the FIFO pointers, level, stage valids and o_done. After reset: o_ready=1, o_wenable=0, o_wlast=0, o_done=0, o_level=0, o_idle=1.
- o_wdata is not reset; it is don't-care while o_wenable=0.

Push:
- A push occurs when i_valid & o_ready.
- o_ready = (level < FIFO_DEPTH), registered-level based.
- There is no write-through at full, even if a pop happens in the same cycle.

Pop:
- The FIFO head moves into stage[0] when the FIFO is non-empty, !i_hold and !i_flush.
- With SKEW_DEPTH=1 this condition also requires the tail stage to be empty or being consumed. Because the pipe advances only as a whole, the rule reduces to !i_hold.

Skew pipe:
- stage[k] holds a valid bit, data and last tag.
- When !i_hold, every stage shifts by one: stage[k] <= stage[k-1], stage[0] <= pop ? head : invalid.
- When i_hold=1, all stages keep their values.
- Outputs: o_wenable/o_wdata/o_wlast come from stage[SKEW_DEPTH-1].
- The array consumes a word when o_wenable & !i_hold.

Latency:
- With an empty block and i_hold=0, a handshake in cycle 0 gives o_wenable=1 in cycle SKEW_DEPTH+1 with that word.
- Back-to-back pushes give back-to-back outputs; sustained throughput is 1 word/cycle.

o_done:
- Registered pulse in the cycle after o_wenable & o_wlast & !i_hold.
- Exactly one cycle wide.

Level:
- o_level updates +1 on push, -1 on pop, unchanged on simultaneous push and pop.
- It never exceeds FIFO_DEPTH and never underflows.

Flush:
- i_flush=1 clears the FIFO pointers, level and all stage valids on the next edge.
- Flush beats a same-cycle push: the word is dropped, but o_ready is still reported as computed.
- Flush overrides i_hold.
- o_done does not fire for a flushed last word.

Reset mid-operation:
- Behaves as flush, and additionally clears o_done.
- The first post-reset push follows the normal latency.

Wrap-around:
- Read and write pointers wrap modulo FIFO_DEPTH.
- Full and empty are distinguished by o_level.

o_idle:
- Combinational: (level==0) & ~|stage_valid.

Test Plan:
1. Reset, SKEW_DEPTH=3, push 0xA5 in cycle 0 with i_hold=0 -> o_wenable=1 and o_wdata=0xA5 only in cycle 4; o_idle=1 from cycle 5.
2. Push 8 words 0..7 back-to-back, last tag on word 7, FIFO_DEPTH=4, i_hold=0 -> outputs 0..7 on consecutive cycles; o_ready never drops; o_done pulses once, in the cycle after word 7 is output.
3. Hold i_hold=1 for cycles 2-9 while pushing 6 words -> o_ready falls once o_level=4; pipe data is frozen; after release, words appear in order with none lost or duplicated.
4. Fill the FIFO to 4 entries, then assert i_flush together with i_valid -> next cycle o_level=0, o_wenable=0, o_idle=1; the pushed word never appears.
5. Stream 20 words with random i_hold (50%) -> output sequence equals input sequence, level is always within 0..4, and pointers wrap at least 4 times.
6. Assert reset while 3 words are in flight and o_wlast is pending -> o_done=0, o_wenable=0 after the edge; a new push in the following cycle emerges SKEW_DEPTH+1 cycles later.
